qr_rotation_scheduler: RTL and testbench

//  Sequencer for a shared, time-multiplexed Givens-rotation QR engine: one rotation unit plus one matmul/update unit.

---
 rtl/qr_rotation_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_qr_rotation_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_rotation_scheduler.sv
// Givens-rotation QR sequencer: walks the sub-diagonal pivot pairs column-major, issuing cos/sin then R/Q update per pair.
// Optional QR_SKIP_ZERO_EN: a rot_done with zero_flag=1 skips the update phase of that pair.
//
// state    | meaning
// IDLE     | waiting for start_valid
// LOAD     | datapath loads R<=matrix, Q<=I; pivot/count/err cleared
// ROT_ISS  | strobe cos/sin generation for (piv_i,piv_j)
// ROT_WAIT | wait for rot_done (watchdog running)
// UPD_ISS  | strobe R/Q update
// UPD_WAIT | wait for upd_done (watchdog running)
// DONE     | result presented until done_ready
module qr_rotation_scheduler #(
  parameter int N        = 4,
  parameter int WDOG_CYC = 64,
  localparam int IDX_W   = $clog2(N),
  localparam int NPAIR   = N*(N-1)/2,
  localparam int CNT_W   = $clog2(NPAIR+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             load_en,
  output logic             rot_issue,
  input  logic             rot_done,
  input  logic             zero_flag,
  output logic             upd_issue,
  input  logic             upd_done,
  output logic [IDX_W-1:0] piv_i,
  output logic [IDX_W-1:0] piv_j,
  output logic             busy,
  output logic [CNT_W-1:0] rot_count,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             err
);

  localparam int WD_W = $clog2(WDOG_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ROT_ISS, S_ROT_WAIT, S_UPD_ISS, S_UPD_WAIT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] piv_i_q, piv_i_d;
  logic [IDX_W-1:0] piv_j_q, piv_j_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             rdy_en_q, rdy_en_d;

  logic skip;
  logic advance;
  logic last_pair;
  logic wd_expired;

`ifdef QR_SKIP_ZERO_EN
  assign skip = zero_flag;
`else
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
  assign skip = 1'b0;
`endif

  assign last_pair  = (piv_i_q == IDX_W'(N-2)) && (piv_j_q == IDX_W'(N-1));
  assign wd_expired = (wd_q == WD_W'(WDOG_CYC-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      piv_i_q  <= '0;
      piv_j_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      piv_i_q  <= piv_i_d;
      piv_j_q  <= piv_j_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    piv_i_d  = piv_i_q;
    piv_j_d  = piv_j_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wd_d     = wd_q;
    rdy_en_d = 1'b1;
    advance  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rdy_en_q holds off acceptance for the first cycle out of reset
        if (start_valid && rdy_en_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        piv_i_d = '0;
        piv_j_d = IDX_W'(1);
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_ROT_ISS;
      end
      S_ROT_ISS: begin
        wd_d    = '0;
        state_d = S_ROT_WAIT;
      end
      S_ROT_WAIT: begin
        if (rot_done) begin
          if (skip) advance = 1'b1;
          else      state_d = S_UPD_ISS;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_UPD_ISS: begin
        wd_d    = '0;
        state_d = S_UPD_WAIT;
      end
      S_UPD_WAIT: begin
        if (upd_done) begin
          advance = 1'b1;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pair completion; the final pair keeps its pivot so DONE reports (N-2,N-1)
    if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_pair) begin
        state_d = S_DONE;
      end else begin
        state_d = S_ROT_ISS;
        if (piv_j_q == IDX_W'(N-1)) begin
          piv_i_d = piv_i_q + IDX_W'(1);
          piv_j_d = piv_i_q + IDX_W'(2);
        end else begin
          piv_j_d = piv_j_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    start_ready = 1'b0;
    load_en     = 1'b0;
    rot_issue   = 1'b0;
    upd_issue   = 1'b0;
    done_valid  = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:    start_ready = rdy_en_q;
      S_LOAD:    load_en     = 1'b1;
      S_ROT_ISS: rot_issue   = 1'b1;
      S_UPD_ISS: upd_issue   = 1'b1;
      S_DONE:    done_valid  = 1'b1;
      default:   ;
    endcase
  end

  assign piv_i     = piv_i_q;
  assign piv_j     = piv_j_q;
  assign rot_count = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_qr_rotation_scheduler.sv
// Scoreboard bench for qr_rotation_scheduler (N=4, WDOG_CYC=64) with a stub rotation/update engine.
// Expectations follow QR_SKIP_ZERO_EN the same way the design does.
module tb_qr_rotation_scheduler;
  localparam int N     = 4;
  localparam int WDOG  = 64;
  localparam int IDX_W = 2;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_valid = 1'b0;
  logic done_ready = 1'b1;
  logic start_ready, load_en, rot_issue, upd_issue, busy, done_valid, err;
  logic rot_done, zero_flag, upd_done;
  logic [IDX_W-1:0] piv_i, piv_j;
  logic [CNT_W-1:0] rot_count;

  logic rot_stub = 1'b0, upd_stub = 1'b0;
  logic inj_rot = 1'b0, inj_upd = 1'b0, zf_en = 1'b0;
  assign rot_done  = rot_stub | inj_rot;
  assign upd_done  = upd_stub | inj_upd;
  assign zero_flag = zf_en & rot_done;

  qr_rotation_scheduler #(.N(N), .WDOG_CYC(WDOG)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .load_en(load_en),
    .rot_issue(rot_issue), .rot_done(rot_done), .zero_flag(zero_flag),
    .upd_issue(upd_issue), .upd_done(upd_done),
    .piv_i(piv_i), .piv_j(piv_j),
    .busy(busy), .rot_count(rot_count),
    .done_valid(done_valid), .done_ready(done_ready), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int acc_cyc = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  typedef struct { int i; int j; } pair_t;
  typedef struct { int cnt; int e; int pi; int pj; int lat; } done_t;
  pair_t exp_rot[$];
  pair_t exp_upd[$];
  done_t exp_done[$];

  int pi_tab[6] = '{0, 0, 0, 1, 1, 2};
  int pj_tab[6] = '{1, 2, 3, 2, 3, 3};
  // cycles from strobe to rot_done per pair; 0 = never answer
  int rot_tab[6] = '{1, 1, 1, 1, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stub engine: answers a strobe seen in cycle c during cycle c+delay
  initial begin
    int rot_cd = 0, upd_cd = 0, pidx = 0;
    forever begin
      @(negedge clk);
      rot_stub = (rot_cd == 1);
      if (rot_cd > 0) rot_cd--;
      upd_stub = (upd_cd == 1);
      if (upd_cd > 0) upd_cd--;
      if (load_en) pidx = 0;
      if (rot_issue) begin
        rot_cd = (pidx < 6) ? rot_tab[pidx] : 1;
        pidx++;
      end
      if (upd_issue) upd_cd = 1;
      if (reset) begin
        rot_cd = 0; upd_cd = 0; rot_stub = 1'b0; upd_stub = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or a result
  initial begin
    logic done_prev = 1'b0;
    pair_t p;
    done_t d;
    forever begin
      @(negedge clk);
      if (reset) done_prev = 1'b0;
      else begin
        if (rot_issue) begin
          if (exp_rot.size() == 0) fail_now("rot_issue_unexpected");
          else begin
            p = exp_rot.pop_front();
            check("rot_piv_i", 32'(piv_i), p.i);
            check("rot_piv_j", 32'(piv_j), p.j);
          end
        end
        if (upd_issue) begin
          if (exp_upd.size() == 0) fail_now("upd_issue_unexpected");
          else begin
            p = exp_upd.pop_front();
            check("upd_piv_i", 32'(piv_i), p.i);
            check("upd_piv_j", 32'(piv_j), p.j);
          end
        end
        if (done_valid && !done_prev) begin
          if (exp_done.size() == 0) fail_now("done_valid_unexpected");
          else begin
            d = exp_done.pop_front();
            check("done_rot_count", 32'(rot_count), d.cnt);
            check("done_err", 32'(err), d.e);
            check("done_piv_i", 32'(piv_i), d.pi);
            check("done_piv_j", 32'(piv_j), d.pj);
            check("done_latency", cyc - acc_cyc, d.lat);
          end
        end
        done_prev = done_valid;
      end
    end
  end

  task automatic push_job(input int n_rot, input int n_upd, input int cnt, input int e,
                          input int pi, input int pj, input int lat);
    pair_t p;
    done_t d;
    for (int k = 0; k < n_rot; k++) begin
      p.i = pi_tab[k]; p.j = pj_tab[k];
      exp_rot.push_back(p);
    end
    for (int k = 0; k < n_upd; k++) begin
      p.i = pi_tab[k]; p.j = pj_tab[k];
      exp_upd.push_back(p);
    end
    d.cnt = cnt; d.e = e; d.pi = pi; d.pj = pj; d.lat = lat;
    exp_done.push_back(d);
  endtask

  task automatic start_job();
    int t = 0;
    while (!start_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!start_ready) fail_now("start_ready_timeout");
    acc_cyc = cyc;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!done_valid) begin
      fail_now({name, "_done_timeout"});
      exp_rot.delete(); exp_upd.delete(); exp_done.delete();
    end
    if (done_ready) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check({name, "_rot_left"}, exp_rot.size(), 0);
    check({name, "_upd_left"}, exp_upd.size(), 0);
    check({name, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({start_ready, load_en, rot_issue, upd_issue, busy, done_valid,
                               err, rot_count, piv_i, piv_j}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("start_ready_after_reset", 32'(start_ready), 1);

    // Test 1: nominal job
    push_job(6, 6, 6, 0, 2, 3, 26);
    start_job();
    wait_done("t1");
    check("t1_idle_start_ready", 32'(start_ready), 1);
    check("t1_idle_busy", 32'(busy), 0);
    check_drained("t1");

    // Test 2: consumer stall
    done_ready = 1'b0;
    push_job(6, 6, 6, 0, 2, 3, 26);
    start_job();
    wait_done("t2");
    for (int k = 0; k < 10; k++) begin
      check("t2_hold", 32'({done_valid, start_ready, busy, piv_i, piv_j, rot_count}),
            32'({1'b1, 1'b0, 1'b1, 2'd2, 2'd3, 3'd6}));
      @(negedge clk);
    end
    done_ready = 1'b1;
    check("t2_accept_cycle_start_ready", 32'(start_ready), 0);
    @(negedge clk);
    check("t2_after_accept", 32'({start_ready, done_valid, busy}), 32'({1'b1, 1'b0, 1'b0}));
    check_drained("t2");

    // Test 3: rot_done withheld on pair 3 -> 64 wait cycles then abort
    rot_tab[2] = 0;
    push_job(3, 2, 2, 1, 0, 3, 10 + 1 + WDOG);
    start_job();
    wait_done("t3");
    check_drained("t3");
    rot_tab[2] = 1;

    // Test 4: reset during UPD_WAIT of pair 4
    push_job(6, 4, 6, 0, 2, 3, 26);
    start_job();
    t = 0;
    while (!(upd_issue && piv_i == 2'd1 && piv_j == 2'd2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("t4_pair4_timeout");
    @(negedge clk);
    reset = 1'b1;
    exp_rot.delete();
    exp_done.delete();
    @(negedge clk);
    check("t4_busy", 32'(busy), 0);
    check("t4_reset_outputs", 32'({start_ready, load_en, rot_issue, upd_issue, done_valid,
                                  err, rot_count, piv_i, piv_j}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("t4_start_ready_after_reset", 32'(start_ready), 1);
    check_drained("t4_abort");
    push_job(6, 6, 6, 0, 2, 3, 26);
    start_job();
    wait_done("t4_fresh");
    check_drained("t4_fresh");

    // Test 5: zero_flag on every pair
    zf_en = 1'b1;
`ifdef QR_SKIP_ZERO_EN
    push_job(6, 0, 6, 0, 2, 3, 14);
`else
    push_job(6, 6, 6, 0, 2, 3, 26);
`endif
    start_job();
    wait_done("t5");
    check_drained("t5");
    zf_en = 1'b0;

    // Test 6: stray done inputs on pair 2; real rot_done 3 cycles after strobe
    rot_tab[1] = 3;
    push_job(6, 6, 6, 0, 2, 3, 28);
    start_job();
    t = 0;
    while (!(rot_issue && piv_i == 2'd0 && piv_j == 2'd2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("t6_pair2_timeout");
    inj_rot = 1'b1;
    @(negedge clk);
    inj_rot = 1'b0;
    inj_upd = 1'b1;
    @(negedge clk);
    inj_upd = 1'b0;
    wait_done("t6");
    check_drained("t6");
    rot_tab[1] = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
